// File: rtl/stage4_mem_pkg.sv
// Shared definitions for the memory-access stage: bus widths, ld_op encodings
// and the execute-to-memory payload layout.
package stage4_mem_pkg;

  localparam int unsigned WIDTH_ES_TO_MS_BUS = 211;
  localparam int unsigned WIDTH_MS_TO_WS_BUS = 204;
  localparam int unsigned WIDTH_MS_TO_DS_BUS = 56;

  // ld_op: bit 0 byte, bit 1 half, bit 2 zero-extend; all-zero is a word load.
  localparam logic [2:0] LDOP_W  = 3'b000;
  localparam logic [2:0] LDOP_B  = 3'b001;
  localparam logic [2:0] LDOP_H  = 3'b010;
  localparam logic [2:0] LDOP_BU = 3'b101;
  localparam logic [2:0] LDOP_HU = 3'b110;

  localparam int unsigned LDOP_BYTE_BIT = 0;
  localparam int unsigned LDOP_HALF_BIT = 1;
  localparam int unsigned LDOP_ZEXT_BIT = 2;

  // Execute-to-memory payload, MSB first.
  typedef struct packed {
    logic        mem_we;        // 210
    logic [31:0] vaddr;         // 209:178
    logic        has_int;       // 177
    logic        brk;           // 176
    logic        ale;           // 175
    logic        ine;           // 174
    logic        adef;          // 173
    logic [14:0] code;          // 172:158
    logic        syscall;       // 157
    logic [31:0] wvalue;        // 156:125
    logic        csr;           // 124
    logic        ertn;          // 123
    logic        csr_write;     // 122
    logic [31:0] wmask;         // 121:90
    logic [13:0] csr_num;       // 89:76
    logic [2:0]  ld_op;         // 75:73
    logic [1:0]  addr_lo;       // 72:71
    logic [31:0] result;        // 70:39
    logic [4:0]  dest;          // 38:34
    logic        res_from_mem;  // 33
    logic        gr_we;         // 32
    logic [31:0] pc;            // 31:0
  } es_bus_t;

endpackage

// File: rtl/stage4_mem_if.sv
// Handshake and bus signals around the memory-access stage.
// master: the surrounding pipeline and data SRAM; slave: the stage itself.
interface stage4_mem_if;

  logic                                          ws_allow_in;
  logic                                          ms_allow_in;
  logic                                          es_to_ms_valid;
  logic [stage4_mem_pkg::WIDTH_ES_TO_MS_BUS-1:0] es_to_ms_bus;
  logic                                          data_sram_req;
  logic                                          data_sram_addr_ok;
  logic                                          data_sram_data_ok;
  logic [31:0]                                   data_sram_rdata;
  logic                                          ms_to_ws_valid;
  logic [stage4_mem_pkg::WIDTH_MS_TO_WS_BUS-1:0] ms_to_ws_bus;
  logic [stage4_mem_pkg::WIDTH_MS_TO_DS_BUS-1:0] ms_to_ds_bus;
  logic                                          if_ms_has_int;

  modport master (
    output ws_allow_in, es_to_ms_valid, es_to_ms_bus, data_sram_req, data_sram_addr_ok,
           data_sram_data_ok, data_sram_rdata,
    input  ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus, if_ms_has_int
  );

  modport slave (
    input  ws_allow_in, es_to_ms_valid, es_to_ms_bus, data_sram_req, data_sram_addr_ok,
           data_sram_data_ok, data_sram_rdata,
    output ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus, if_ms_has_int
  );

endinterface

// File: rtl/ms_load_align.sv
// Selects the addressed byte/half of a load response and sign/zero-extends it.
module ms_load_align
  import stage4_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_op,
  output logic [31:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  // Lane select then extension; word loads pass through untouched.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sext     = ~ld_op[LDOP_ZEXT_BIT];
    aligned  = rdata;
    if (ld_op[LDOP_BYTE_BIT]) begin
      aligned = {{24{sext & byte_sel[7]}}, byte_sel};
    end else if (ld_op[LDOP_HALF_BIT]) begin
      aligned = {{16{sext & half_sel[15]}}, half_sel};
    end
  end

endmodule

// File: rtl/stage4_mem.sv
// Memory-access pipeline stage: waits for data_sram responses, aligns load data,
// forwards the CSR/exception payload to writeback and hazard info to decode, and
// discards responses belonging to flushed requests.
// Optional: define MS_RDATA_BUF_EN to hold a response while writeback stalls.
module stage4_mem
  import stage4_mem_pkg::*;
#(
  parameter int unsigned CANCEL_W = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ertn_flush,
  input  logic           wb_ex,
  stage4_mem_if.slave    ms
);

  localparam int unsigned       SUM_W   = CANCEL_W + 2;
  localparam logic [SUM_W-1:0]  CNT_MAX = SUM_W'((1 << CANCEL_W) - 1);

  logic                flush;
  logic                ms_valid_q, ms_valid_d;
  es_bus_t             bus_q, bus_d;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;
  logic                exc_any, req_issued, data_ok_live, resp_here;
  logic                ms_ready_go, ms_allow_in, ms_to_ws_valid, ld_wait;
  logic [31:0]         mem_rdata, aligned, final_result;
  logic [1:0]          cnt_inc;
  logic                cnt_dec;
  logic [SUM_W-1:0]    cnt_sum;

  assign flush        = ertn_flush | wb_ex;
  assign exc_any      = bus_q.adef | bus_q.ine | bus_q.ale | bus_q.brk | bus_q.syscall |
                        bus_q.ertn | bus_q.has_int;
  // Faulting instructions never reached the SRAM, so they never wait.
  assign req_issued   = (bus_q.mem_we | bus_q.res_from_mem) & ~exc_any;
  // While cancels are outstanding, any response belongs to a flushed request.
  assign data_ok_live = ms.data_sram_data_ok & (cancel_cnt_q == '0);

`ifdef MS_RDATA_BUF_EN
  logic        rdata_buf_v_q, rdata_buf_v_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  // Hold an accepted response until writeback takes the instruction.
  always_comb begin
    rdata_buf_v_d = rdata_buf_v_q;
    rdata_buf_d   = rdata_buf_q;
    if (flush || (ms_to_ws_valid && ms.ws_allow_in)) begin
      rdata_buf_v_d = 1'b0;
    end else if (ms_valid_q && req_issued && data_ok_live && !ms.ws_allow_in) begin
      rdata_buf_v_d = 1'b1;
      rdata_buf_d   = ms.data_sram_rdata;
    end
  end

  // Response buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf_v_q <= 1'b0;
      rdata_buf_q   <= '0;
    end else begin
      rdata_buf_v_q <= rdata_buf_v_d;
      rdata_buf_q   <= rdata_buf_d;
    end
  end

  assign resp_here = data_ok_live | rdata_buf_v_q;
  assign mem_rdata = rdata_buf_v_q ? rdata_buf_q : ms.data_sram_rdata;
`else
  assign resp_here = data_ok_live;
  assign mem_rdata = ms.data_sram_rdata;

  // With no buffer the response is lost unless writeback takes it at once.
  assert property (@(posedge clk) disable iff (reset)
    (ms_valid_q && req_issued && data_ok_live) |-> ms.ws_allow_in);
`endif

  assign ms_ready_go    = ~req_issued | resp_here;
  assign ms_allow_in    = ~ms_valid_q | (ms_ready_go & ms.ws_allow_in);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ld_wait        = ms_valid_q & bus_q.res_from_mem & ~ms_ready_go;

  ms_load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (bus_q.addr_lo),
    .ld_op   (bus_q.ld_op),
    .aligned (aligned)
  );

  assign final_result = bus_q.res_from_mem ? aligned : bus_q.result;

  // Pipeline valid and payload: flush wins over a new acceptance.
  always_comb begin
    ms_valid_d = ms_valid_q;
    bus_d      = bus_q;
    if (flush) begin
      ms_valid_d = 1'b0;
      bus_d      = '0;
    end else if (ms_allow_in) begin
      ms_valid_d = ms.es_to_ms_valid;
      if (ms.es_to_ms_valid) begin
        bus_d = es_bus_t'(ms.es_to_ms_bus);
      end
    end
  end

  // Count in-flight requests orphaned by a flush; each later response retires one.
  always_comb begin
    cnt_inc = 2'b00;
    if (flush) begin
      cnt_inc = 2'(ms_valid_q & req_issued & ~resp_here) +
                2'(ms.data_sram_req & ms.data_sram_addr_ok);
    end
    cnt_dec      = ms.data_sram_data_ok & (cancel_cnt_q != '0);
    cnt_sum      = SUM_W'(cancel_cnt_q) + SUM_W'(cnt_inc) - SUM_W'(cnt_dec);
    cancel_cnt_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CANCEL_W-1:0] : cnt_sum[CANCEL_W-1:0];
  end

  // Stage state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      bus_q        <= '0;
      cancel_cnt_q <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      bus_q        <= bus_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  assign ms.ms_allow_in    = ms_allow_in;
  assign ms.ms_to_ws_valid = ms_to_ws_valid;
  assign ms.ms_to_ws_bus   = {bus_q.vaddr,
                              bus_q.has_int, bus_q.brk, bus_q.ale, bus_q.ine, bus_q.adef,
                              bus_q.code, bus_q.syscall, bus_q.wvalue, bus_q.csr, bus_q.ertn,
                              bus_q.csr_write, bus_q.wmask, bus_q.csr_num,
                              final_result, bus_q.dest, bus_q.gr_we, bus_q.pc};
  assign ms.ms_to_ds_bus   = {ms_valid_q, bus_q.gr_we, bus_q.dest, ld_wait, final_result,
                              bus_q.csr_write, bus_q.csr_num, bus_q.csr};
  assign ms.if_ms_has_int  = ms_valid_q & exc_any;

endmodule

// File: tb/tb_stage4_mem.sv
// Directed bench for stage4_mem: table of load/store/ALU vectors plus hand-written
// flush, cancel-counter, reset and (optionally) response-buffer sequences.
module tb_stage4_mem;

  logic clk = 1'b0;
  logic reset, ertn_flush, wb_ex;
  int   checks   = 0;
  int   failures = 0;

  stage4_mem_if ms_if ();

  stage4_mem #(.CANCEL_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ertn_flush (ertn_flush),
    .wb_ex      (wb_ex),
    .ms         (ms_if)
  );

  always #5 clk = ~clk;

  logic [31:0] ws_result, ds_result;
  logic        ld_wait, ds_valid;
  assign ws_result = ms_if.ms_to_ws_bus[69:38];
  assign ds_result = ms_if.ms_to_ds_bus[47:16];
  assign ld_wait   = ms_if.ms_to_ds_bus[48];
  assign ds_valid  = ms_if.ms_to_ds_bus[55];

  typedef struct {
    string       name;
    logic        rfm;
    logic        mwe;
    logic [2:0]  op;
    logic [1:0]  alo;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [210:0] mk_bus(input logic [31:0] pc, input logic rfm,
                                          input logic mwe, input logic [2:0] op,
                                          input logic [1:0] alo, input logic [31:0] res,
                                          input logic ale);
    logic [210:0] b;
    b            = '0;
    b[31:0]      = pc;
    b[32]        = rfm;
    b[33]        = rfm;
    b[38:34]     = 5'd7;
    b[70:39]     = res;
    b[72:71]     = alo;
    b[75:73]     = op;
    b[175]       = ale;
    b[209:178]   = {30'h0000_0400, alo};
    b[210]       = mwe;
    return b;
  endfunction

  task automatic issue(input logic [210:0] b);
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = b;
    tick();
    ms_if.es_to_ms_valid = 1'b0;
  endtask

  // Issue one op, wait lat cycles, deliver the response, check the handoff.
  task automatic run_vec(input vec_t v, input int idx);
    int   waits;
    logic early;
    logic [31:0] pc;
    pc    = 32'h0000_2000 + 32'(idx * 4);
    waits = 0;
    early = 1'b0;
    issue(mk_bus(pc, v.rfm, v.mwe, v.op, v.alo, 32'h5A5A_0000 + 32'(idx), 1'b0));
    for (int c = 0; c < v.lat; c++) begin
      @(negedge clk);
      if (ld_wait) waits++;
      if (ms_if.ms_to_ws_valid) early = 1'b1;
      tick();
    end
    if (v.rfm || v.mwe) begin
      ms_if.data_sram_data_ok = 1'b1;
      ms_if.data_sram_rdata   = v.rdata;
    end
    @(negedge clk);
    check($sformatf("%s_valid", v.name), ms_if.ms_to_ws_valid, 1);
    check($sformatf("%s_result", v.name), ws_result, v.exp);
    check($sformatf("%s_ds_result", v.name), ds_result, v.exp);
    check($sformatf("%s_pc", v.name), ms_if.ms_to_ws_bus[31:0], pc);
    check($sformatf("%s_wait_cycles", v.name), waits, v.rfm ? v.lat : 0);
    check($sformatf("%s_early_valid", v.name), early, 0);
    tick();
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
    @(negedge clk);
    check($sformatf("%s_retired", v.name), ms_if.ms_to_ws_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [210:0] b;
    logic [203:0] exp_ws;
    logic [55:0]  exp_ds;
    vec_t         v;

    vecs[0] = '{"ld_w",   1'b1, 1'b0, 3'b000, 2'd0, 32'h89AB_CDEF, 3, 32'h89AB_CDEF};
    vecs[1] = '{"ld_b3",  1'b1, 1'b0, 3'b001, 2'd3, 32'h80FF_FFFF, 1, 32'hFFFF_FF80};
    vecs[2] = '{"ld_bu3", 1'b1, 1'b0, 3'b101, 2'd3, 32'h80FF_FFFF, 1, 32'h0000_0080};
    vecs[3] = '{"ld_h2",  1'b1, 1'b0, 3'b010, 2'd2, 32'h80FF_FFFF, 0, 32'hFFFF_80FF};
    vecs[4] = '{"ld_hu0", 1'b1, 1'b0, 3'b110, 2'd0, 32'h1234_F00D, 2, 32'h0000_F00D};
    vecs[5] = '{"ld_b1",  1'b1, 1'b0, 3'b001, 2'd1, 32'h0000_A500, 1, 32'hFFFF_FFA5};
    vecs[6] = '{"ld_h0",  1'b1, 1'b0, 3'b010, 2'd0, 32'hFFFF_7FFF, 1, 32'h0000_7FFF};
    vecs[7] = '{"st_w",   1'b0, 1'b1, 3'b000, 2'd0, 32'h0BAD_0BAD, 1, 32'h5A5A_0007};
    vecs[8] = '{"alu",    1'b0, 1'b0, 3'b000, 2'd0, 32'h0,         0, 32'h5A5A_0008};

    reset                   = 1'b1;
    ertn_flush              = 1'b0;
    wb_ex                   = 1'b0;
    ms_if.ws_allow_in       = 1'b1;
    ms_if.es_to_ms_valid    = 1'b0;
    ms_if.es_to_ms_bus      = '0;
    ms_if.data_sram_req     = 1'b0;
    ms_if.data_sram_addr_ok = 1'b0;
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'h0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_allow_in", ms_if.ms_allow_in, 1);
    check("rst_ws_valid", ms_if.ms_to_ws_valid, 0);
    check("rst_ws_bus", ms_if.ms_to_ws_bus, 0);
    check("rst_ds_bus", ms_if.ms_to_ds_bus, 0);
    check("rst_has_int", ms_if.if_ms_has_int, 0);
    check("rst_cnt", dut.cancel_cnt_q, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Full payload passthrough for a non-memory op carrying CSR fields.
    b           = mk_bus(32'h0000_4000, 1'b0, 1'b0, 3'b000, 2'd0, 32'hA1B2_C3D4, 1'b0);
    b[32]       = 1'b1;
    b[89:76]    = 14'h1ABC;
    b[121:90]   = 32'hF0F0_1234;
    b[122]      = 1'b1;
    b[124]      = 1'b1;
    b[156:125]  = 32'hDEAD_0042;
    b[172:158]  = 15'h1234;
    exp_ws      = {b[209:178], b[177:76], b[70:39], b[38:34], b[32], b[31:0]};
    exp_ds      = {1'b1, 1'b1, 5'd7, 1'b0, 32'hA1B2_C3D4, 1'b1, 14'h1ABC, 1'b1};
    issue(b);
    @(negedge clk);
    check("pass_ws_bus", ms_if.ms_to_ws_bus, exp_ws);
    check("pass_ds_bus", ms_if.ms_to_ds_bus, exp_ds);
    check("pass_has_int", ms_if.if_ms_has_int, 0);

    // ALE on a load: no wait, exception visible, no response expected.
    tick();
    issue(mk_bus(32'h0000_3000, 1'b1, 1'b0, 3'b000, 2'd1, 32'h0, 1'b1));
    @(negedge clk);
    check("ale_valid", ms_if.ms_to_ws_valid, 1);
    check("ale_has_int", ms_if.if_ms_has_int, 1);
    check("ale_ld_wait", ld_wait, 0);
    tick();
    @(negedge clk);
    check("ale_retired", ms_if.ms_to_ws_valid, 0);

    // wb_ex while a load waits: response later discarded.
    issue(mk_bus(32'h0000_5000, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 1'b0));
    @(negedge clk);
    check("wbex_wait", ld_wait, 1);
    wb_ex = 1'b1;
    tick();
    wb_ex = 1'b0;
    @(negedge clk);
    check("wbex_ms_valid", ds_valid, 0);
    check("wbex_cnt", dut.cancel_cnt_q, 1);
    check("wbex_allow_in", ms_if.ms_allow_in, 1);
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check("wbex_stale_fwd", ms_if.ms_to_ws_valid, 0);
    tick();
    ms_if.data_sram_data_ok = 1'b0;
    @(negedge clk);
    check("wbex_cnt_drained", dut.cancel_cnt_q, 0);
    check("wbex_stale_state", ds_valid, 0);
    v = '{"wbex_next", 1'b1, 1'b0, 3'b000, 2'd0, 32'h1122_3344, 1, 32'h1122_3344};
    run_vec(v, 20);

    // ertn with an upstream handshake and our own load in flight: two cancels.
    issue(mk_bus(32'h0000_6000, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 1'b0));
    @(negedge clk);
    ertn_flush              = 1'b1;
    ms_if.data_sram_req     = 1'b1;
    ms_if.data_sram_addr_ok = 1'b1;
    tick();
    ertn_flush              = 1'b0;
    ms_if.data_sram_req     = 1'b0;
    ms_if.data_sram_addr_ok = 1'b0;
    @(negedge clk);
    check("ertn_cnt2", dut.cancel_cnt_q, 2);
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'h0BAD_0001;
    #1;
    check("ertn_drop1_fwd", ms_if.ms_to_ws_valid, 0);
    tick();
    @(negedge clk);
    check("ertn_cnt1", dut.cancel_cnt_q, 1);
    check("ertn_drop2_fwd", ms_if.ms_to_ws_valid, 0);
    tick();
    ms_if.data_sram_data_ok = 1'b0;
    @(negedge clk);
    check("ertn_cnt0", dut.cancel_cnt_q, 0);
    v = '{"ertn_next", 1'b1, 1'b0, 3'b000, 2'd0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D};
    run_vec(v, 21);

    // Response in the same cycle as the flush completes the request: no cancel.
    issue(mk_bus(32'h0000_7000, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 1'b0));
    @(negedge clk);
    wb_ex                   = 1'b1;
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'h7777_7777;
    tick();
    wb_ex                   = 1'b0;
    ms_if.data_sram_data_ok = 1'b0;
    @(negedge clk);
    check("same_cycle_cnt", dut.cancel_cnt_q, 0);
    check("same_cycle_valid", ds_valid, 0);

    // Counter saturates at 3, then drains one per response.
    for (int i = 0; i < 4; i++) begin
      ertn_flush              = 1'b1;
      ms_if.data_sram_req     = 1'b1;
      ms_if.data_sram_addr_ok = 1'b1;
      tick();
      @(negedge clk);
      check($sformatf("sat_up%0d", i), dut.cancel_cnt_q, (i < 3) ? i + 1 : 3);
    end
    ertn_flush              = 1'b0;
    ms_if.data_sram_req     = 1'b0;
    ms_if.data_sram_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ms_if.data_sram_data_ok = 1'b1;
      tick();
      @(negedge clk);
      check($sformatf("sat_down%0d", i), dut.cancel_cnt_q, 2 - i);
    end
    ms_if.data_sram_data_ok = 1'b0;

    // Reset mid-wait with cancels outstanding clears everything.
    @(negedge clk);
    ertn_flush              = 1'b1;
    ms_if.data_sram_req     = 1'b1;
    ms_if.data_sram_addr_ok = 1'b1;
    tick();
    ertn_flush              = 1'b0;
    ms_if.data_sram_req     = 1'b0;
    ms_if.data_sram_addr_ok = 1'b0;
    issue(mk_bus(32'h0000_8000, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 1'b0));
    @(negedge clk);
    check("rstmid_wait", ld_wait, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_valid", ds_valid, 0);
    check("rstmid_allow_in", ms_if.ms_allow_in, 1);
    check("rstmid_cnt", dut.cancel_cnt_q, 0);

`ifdef MS_RDATA_BUF_EN
    // Writeback stalls for two cycles; the buffered response survives.
    issue(mk_bus(32'h0000_9000, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0, 1'b0));
    @(negedge clk);
    ms_if.ws_allow_in       = 1'b0;
    ms_if.data_sram_data_ok = 1'b1;
    ms_if.data_sram_rdata   = 32'h1234_5678;
    tick();
    ms_if.data_sram_data_ok = 1'b0;
    ms_if.data_sram_rdata   = 32'hFFFF_0000;
    @(negedge clk);
    check("buf_hold1_valid", ms_if.ms_to_ws_valid, 1);
    check("buf_hold1_result", ws_result, 32'h1234_5678);
    check("buf_hold1_allow_in", ms_if.ms_allow_in, 0);
    ms_if.ws_allow_in = 1'b1;
    #1;
    check("buf_release_result", ws_result, 32'h1234_5678);
    tick();
    @(negedge clk);
    check("buf_retired", ms_if.ms_to_ws_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
